// File: rtl/mux_pipe_pkg.sv
// Shared definitions for the pipelined N-to-1 lane selector.
// Holds the index-width helper and the tag that travels with each request.
package mux_pipe_pkg;

    // Widest lane index the pipeline tag can carry (N up to 65536 lanes).
    localparam int IDX_MAXW = 16;

    // Width of a select index for n choices; never narrower than one bit.
    function automatic int lane_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Per-request bookkeeping carried alongside the data down the pipe.
    typedef struct packed {
        logic [IDX_MAXW-1:0] idx;
        logic                err;
    } pipe_tag_t;

endpackage

// File: rtl/mux_grp_sel.sv
// Combinational NL-to-1 selector of LW-bit lanes.
// A select value with no matching lane yields zero, which gives the
// zero-fill behaviour for groups that lie past the last real lane.
module mux_grp_sel #(
    parameter int LW = 4,
    parameter int NL = 16,
    parameter int SW = 4
) (
    input  logic [NL*LW-1:0] i_lanes,
    input  logic [SW-1:0]    i_sel,
    output logic [LW-1:0]    o_lane
);

    // Pick the lane whose position matches the select, zero otherwise.
    always_comb begin
        o_lane = '0;
        for (int k = 0; k < NL; k++) begin
            if (int'(i_sel) == k) begin
                o_lane = i_lanes[k*LW +: LW];
            end
        end
    end

endmodule

// File: rtl/mux_pipe_nto1v.sv
// Pipelined N-to-1 selector of W-bit lanes with valid/ready on both sides.
// Stage 1 narrows the wide input to one group of G lanes, stage 2 picks the
// lane inside that group. An optional scan pointer supplies the index.
module mux_pipe_nto1v
    import mux_pipe_pkg::*;
#(
    parameter int W    = 4,
    parameter int N    = 256,
    parameter int G    = 16,
    parameter int SELW = lane_idx_w(N)
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic [N*W-1:0]  in,
    input  logic [SELW-1:0] sel,
    input  logic            scan_en,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [W-1:0]    out,
    output logic [SELW-1:0] out_idx,
    output logic            out_err,
    output logic            out_valid,
    input  logic            out_ready
);

    localparam int NG  = (N + G - 1) / G;
    localparam int NP  = NG * G;
    localparam int GSW = lane_idx_w(G);

    logic [NP*W-1:0] w_inPad;
    logic [SELW-1:0] w_idx;
    logic [SELW-1:0] w_grp;
    logic            w_err1;
    logic [G*W-1:0]  w_slice;
    logic [GSW-1:0]  w_lane;
    logic [W-1:0]    w_pick;
    logic            w_en1;
    logic            w_en2;
    logic            w_accept;
    pipe_tag_t       w_tag;

    logic            r_v1;
    logic            r_v2;
    logic [G*W-1:0]  r_slice;
    pipe_tag_t       r_tag1;
    pipe_tag_t       r_tag2;
    logic [W-1:0]    r_out;
    logic [SELW-1:0] r_ptr;

    assign w_en2    = !r_v2 || out_ready;
    assign w_en1    = !r_v1 || w_en2;
    assign in_ready = w_en1;
    assign w_accept = in_valid && w_en1;

    assign w_idx  = scan_en ? r_ptr : sel;
    assign w_err1 = int'(w_idx) >= N;
    assign w_grp  = SELW'(int'(w_idx) / G);

    assign w_tag.idx = IDX_MAXW'(w_idx);
    assign w_tag.err = w_err1;

    // Extend the input to whole groups; lanes past N read as zero.
    always_comb begin
        w_inPad            = '0;
        w_inPad[N*W-1:0]   = in;
    end

    mux_grp_sel #(.LW(G*W), .NL(NG), .SW(SELW)) u_stage1Sel (
        .i_lanes (w_inPad),
        .i_sel   (w_grp),
        .o_lane  (w_slice)
    );

    assign w_lane = GSW'(int'(r_tag1.idx) % G);

    mux_grp_sel #(.LW(W), .NL(G), .SW(GSW)) u_stage2Sel (
        .i_lanes (r_slice),
        .i_sel   (w_lane),
        .o_lane  (w_pick)
    );

    // Stage 1: capture the group slice and tag when a request is accepted.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v1    <= 1'b0;
            r_slice <= '0;
            r_tag1  <= '0;
        end else if (w_en1) begin
            r_v1 <= in_valid;
            if (in_valid) begin
                r_slice <= w_slice;
                r_tag1  <= w_tag;
            end
        end
    end

    // Stage 2: pick the lane within the group and hold it until consumed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_v2   <= 1'b0;
            r_out  <= '0;
            r_tag2 <= '0;
        end else if (w_en2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_out  <= r_tag1.err ? '0 : w_pick;
                r_tag2 <= r_tag1;
            end
        end
    end

    // Scan pointer advances only on scan-mode accepts, wrapping at N-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ptr <= '0;
        end else if (w_accept && scan_en) begin
            r_ptr <= (int'(r_ptr) == N - 1) ? '0 : r_ptr + 1'b1;
        end
    end

    assign out       = r_out;
    assign out_idx   = SELW'(r_tag2.idx);
    assign out_err   = r_tag2.err;
    assign out_valid = r_v2;

endmodule
